// File: rtl/record_word_packer_pkg.sv
// Shared constants, record field map and serializer state for record_word_packer.
package record_word_packer_pkg;

  localparam int REC_W         = 47;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_REC = 3;

  localparam int TS_LSB   = 0;
  localparam int TS_MSB   = 35;
  localparam int CH_LSB   = 36;
  localparam int CH_MSB   = 39;
  localparam int TYPE_BIT = 45;
  localparam int WRAP_BIT = 46;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_W0   = 2'd1,
    SER_W1   = 2'd2,
    SER_W2   = 2'd3
  } ser_state_e;

  // Word presented on the host side for a given serializer state; low word first.
  function automatic logic [WORD_W-1:0] rec_word(input logic [REC_W-1:0] rec,
                                                 input ser_state_e st);
    logic [WORD_W-1:0] w;
    w = '0;
    case (st)
      SER_W0:  w = rec[15:0];
      SER_W1:  w = rec[31:16];
      SER_W2:  w = {1'b0, rec[WRAP_BIT:32]};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/record_word_packer_if.sv
// Record strobe input and word valid/ack output of record_word_packer.
interface record_word_packer_if;
  import record_word_packer_pkg::*;

  logic [REC_W-1:0]  rec_data;
  logic              rec_ready;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ack;

  modport master (output rec_data, rec_ready, out_ack,
                  input  out_word, out_valid);

  modport slave  (input  rec_data, rec_ready, out_ack,
                  output out_word, out_valid);

endinterface

// File: rtl/record_word_packer_sync_fifo.sv
// Single-clock FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH      = 47,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  do_push, do_pop;

  assign full_o    = (level_q == LVL_FULL);
  assign empty_o   = (level_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Storage is only written on an accepted push, so undriven data never lands here.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/record_word_packer.sv
// Buffers 47-bit time-tag records and serialises each as three 16-bit words.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   SER_IDLE | nothing held; pop head as soon as FIFO non-empty
//   SER_W0   | presenting hold[15:0]
//   SER_W1   | presenting hold[31:16]
//   SER_W2   | presenting {0, hold[46:32]}; ack pops next record
module record_word_packer
  import record_word_packer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7,
  parameter int LOST_W     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  record_word_packer_if.slave bus,
  input  logic                clear_lost,
  output logic [LOST_W-1:0]   lost_count,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] fifo_level
);

  logic [REC_W-1:0]  fifo_rd;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic              drop;

  ser_state_e        state_q, state_d;
  logic [REC_W-1:0]  hold_q, hold_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              ack_acc;

  logic [LOST_W-1:0] lost_q, lost_d;
  logic              ovf_q, ovf_d;

  sync_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (bus.rec_ready),
    .wr_data_i (bus.rec_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Full is the registered level, so a same-edge pop never rescues a push.
  assign drop = bus.rec_ready && fifo_full;

  always_comb begin
    lost_d = lost_q;
    ovf_d  = ovf_q;
    if (clear_lost) begin
      lost_d = '0;
      ovf_d  = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (lost_d != '1) lost_d = lost_d + LOST_W'(1);
    end
  end

  assign ack_acc = valid_q && bus.out_ack;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rd;
          state_d  = SER_W0;
        end
      end
      SER_W0: if (ack_acc) state_d = SER_W1;
      SER_W1: if (ack_acc) state_d = SER_W2;
      SER_W2: begin
        if (ack_acc) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            hold_d   = fifo_rd;
            state_d  = SER_W0;
          end else begin
            state_d  = SER_IDLE;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
    word_d  = rec_word(hold_d, state_d);
    valid_d = (state_d != SER_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SER_IDLE;
      hold_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      lost_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_word  = word_q;
  assign bus.out_valid = valid_q;
  assign lost_count    = lost_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_record_word_packer.sv
// Self-checking bench for record_word_packer: vector table, scoreboard model, corner sequences.
module tb_record_word_packer;
  import record_word_packer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        clear_lost;
  logic [15:0] lost_count;
  logic        overflow;
  logic [7:0]  fifo_level;

  record_word_packer_if bus ();
  record_word_packer #(.DEPTH_LOG2(7), .LOST_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .clear_lost(clear_lost),
    .lost_count(lost_count), .overflow(overflow), .fifo_level(fifo_level));

  // Small instance: depth 4, 4-bit lost counter, so saturation is reachable quickly.
  logic       s_clear;
  logic [3:0] s_lost;
  logic       s_ovf;
  logic [2:0] s_level;
  record_word_packer_if sbus ();
  record_word_packer #(.DEPTH_LOG2(2), .LOST_W(4)) sdut (
    .clk(clk), .reset_n(reset_n), .bus(sbus), .clear_lost(s_clear),
    .lost_count(s_lost), .overflow(s_ovf), .fifo_level(s_level));

  int checks = 0;
  int errors = 0;

  int          m_level, m_state, words_acc;
  int unsigned m_lost;
  bit          m_ovf;
  logic [15:0] wq[$];

  typedef struct {
    bit          rdy;
    logic [46:0] d;
    bit          ack;
    bit          ev;
    logic [15:0] ew;
    logic [7:0]  el;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_state = 0; m_lost = 0; m_ovf = 0;
    wq.delete();
  endtask

  // One cycle: drive at the falling edge, compare DUT against model, advance model past the next rising edge.
  task automatic step(input bit rdy, input logic [46:0] d, input bit ack, input bit clr);
    bit push_ok, drop, pop;
    @(negedge clk);
    bus.rec_ready = rdy;
    bus.rec_data  = rdy ? d : 47'bx;
    bus.out_ack   = ack;
    clear_lost    = clr;
    chk("level", 64'(fifo_level), 64'(m_level));
    chk("valid", 64'(bus.out_valid), 64'(m_state != 0));
    if (m_state != 0) begin
      if (wq.size() > 0) chk("word", 64'(bus.out_word), 64'(wq[0]));
      else begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow: got word %0h expected none", bus.out_word);
      end
    end
    chk("lost", 64'(lost_count), 64'(m_lost));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    push_ok = rdy && (m_level < 128);
    drop    = rdy && (m_level >= 128);
    pop     = (m_level > 0) && ((m_state == 0) || (m_state == 3 && ack));
    if (m_state != 0 && ack) begin
      if (wq.size() > 0) void'(wq.pop_front());
      words_acc++;
    end
    if (push_ok) begin
      wq.push_back(d[15:0]);
      wq.push_back(d[31:16]);
      wq.push_back({1'b0, d[46:32]});
    end
    case (m_state)
      0:       m_state = pop ? 1 : 0;
      1, 2:    m_state = ack ? m_state + 1 : m_state;
      default: m_state = ack ? (pop ? 1 : 0) : 3;
    endcase
    m_level = m_level + int'(push_ok) - int'(pop);
    if (clr) begin m_lost = 0; m_ovf = 0; end
    if (drop) begin
      m_ovf = 1;
      if (m_lost < 32'hFFFF) m_lost++;
    end
  endtask

  task automatic drain();
    int budget = 0;
    while ((m_state != 0 || m_level != 0) && budget < 2000) begin
      step(1'b0, 47'b0, 1'b1, 1'b0);
      budget++;
    end
    chk("drain_in_budget", 64'(budget < 2000), 64'(1));
    step(1'b0, 47'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w_start, first_v, last_v, n_v;

    tbl[0]  = '{1, 47'h2234_5678_9ABC, 1, 0, 16'h0000, 8'd0};
    tbl[1]  = '{0, 47'h0,              1, 0, 16'h0000, 8'd1};
    tbl[2]  = '{0, 47'h0,              1, 1, 16'h9ABC, 8'd0};
    tbl[3]  = '{0, 47'h0,              1, 1, 16'h5678, 8'd0};
    tbl[4]  = '{0, 47'h0,              1, 1, 16'h2234, 8'd0};
    tbl[5]  = '{1, 47'h7FFF_FFFF_FFFF, 1, 0, 16'h0000, 8'd0};
    tbl[6]  = '{0, 47'h0,              1, 0, 16'h0000, 8'd1};
    tbl[7]  = '{0, 47'h0,              1, 1, 16'hFFFF, 8'd0};
    tbl[8]  = '{0, 47'h0,              1, 1, 16'hFFFF, 8'd0};
    tbl[9]  = '{0, 47'h0,              1, 1, 16'h7FFF, 8'd0};
    tbl[10] = '{0, 47'h0,              1, 0, 16'h0000, 8'd0};

    reset_n = 1'b0; clear_lost = 1'b0;
    bus.rec_ready = 1'b0; bus.rec_data = '0; bus.out_ack = 1'b0;
    s_clear = 1'b0; sbus.rec_ready = 1'b0; sbus.rec_data = '0; sbus.out_ack = 1'b0;
    model_reset();
    words_acc = 0;
    #22;
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_word", 64'(bus.out_word), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_lost", 64'(lost_count), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Single records: latency, level 1 then 0, field split including bit 46 and zero bit 15.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rdy, tbl[i].d, tbl[i].ack, 1'b0);
      chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_word", 64'(bus.out_word), 64'(tbl[i].ew));
      chk("tbl_level", 64'(fifo_level), 64'(tbl[i].el));
    end

    // Overflow: 131 records with no ack; 1 held, 128 stored, 2 dropped.
    for (int ts = 0; ts < 131; ts++) step(1'b1, 47'(ts), 1'b0, 1'b0);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    chk("ovf_level", 64'(fifo_level), 64'(128));
    chk("ovf_lost", 64'(lost_count), 64'(2));
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_head_word", 64'(bus.out_word), 64'(0));
    w_start = words_acc;
    drain();
    chk("ovf_drain_words", 64'(words_acc - w_start), 64'(129 * 3));
    chk("ovf_sb_empty", 64'(wq.size()), 64'(0));

    step(1'b0, 47'b0, 1'b0, 1'b1);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    chk("clear_lost", 64'(lost_count), 64'(0));
    chk("clear_ovf", 64'(overflow), 64'(0));

    // Push at full coincident with pop is dropped; at 127 it is accepted.
    for (int i = 0; i < 129; i++) step(1'b1, 47'h100 + 47'(i), 1'b0, 1'b0);
    step(1'b0, 47'b0, 1'b1, 1'b0);
    step(1'b0, 47'b0, 1'b1, 1'b0);
    step(1'b1, 47'h5555, 1'b1, 1'b0);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    chk("full_pop_level", 64'(fifo_level), 64'(127));
    chk("full_pop_lost", 64'(lost_count), 64'(1));
    step(1'b0, 47'b0, 1'b1, 1'b0);
    step(1'b0, 47'b0, 1'b1, 1'b0);
    step(1'b1, 47'h6666, 1'b1, 1'b0);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    chk("l127_pop_level", 64'(fifo_level), 64'(127));
    chk("l127_pop_lost", 64'(lost_count), 64'(1));
    drain();

    // Ack stall in W1.
    step(1'b1, 47'h0ABC_DEF0_1234, 1'b0, 1'b0);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    step(1'b0, 47'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 47'b0, 1'b0, 1'b0);
      chk("stall_word", 64'(bus.out_word), 64'(16'hDEF0));
      chk("stall_valid", 64'(bus.out_valid), 64'(1));
    end
    step(1'b0, 47'b0, 1'b1, 1'b0);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    chk("stall_w2_word", 64'(bus.out_word), 64'(16'h0ABC));
    drain();

    // Back-to-back: 4 records yield 12 contiguous valid words.
    first_v = -1; last_v = -1; n_v = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) step(1'b1, 47'h7000_0000_0000 + 47'(i), 1'b1, 1'b0);
      else       step(1'b0, 47'b0, 1'b1, 1'b0);
      if (bus.out_valid) begin
        n_v++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    chk("b2b_valid_count", 64'(n_v), 64'(12));
    chk("b2b_contiguous", 64'(last_v - first_v + 1), 64'(12));
    drain();

    // Reset mid-W1 with 10 records queued; lost_count is non-zero beforehand.
    step(1'b1, 47'h1_0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 47'h2_0000 + 47'(i), 1'b0, 1'b0);
    step(1'b0, 47'b0, 1'b1, 1'b0);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 64'(fifo_level), 64'(10));
    chk("pre_rst_lost", 64'(lost_count), 64'(1));
    @(negedge clk);
    reset_n = 1'b0;
    bus.out_ack = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_level", 64'(fifo_level), 64'(0));
    chk("mid_rst_lost", 64'(lost_count), 64'(0));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 47'h1234_5678_9ABC, 1'b0, 1'b0);
    step(1'b0, 47'b0, 1'b0, 1'b0);
    step(1'b0, 47'b0, 1'b1, 1'b0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'(1));
    chk("post_rst_w0", 64'(bus.out_word), 64'(16'h9ABC));
    drain();

    // Small instance: saturation, clear from saturated, clear with same-edge drop.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      sbus.rec_ready = 1'b1;
      sbus.rec_data  = 47'(i);
    end
    @(negedge clk);
    sbus.rec_ready = 1'b0;
    chk("sat_lost", 64'(s_lost), 64'(4'hF));
    chk("sat_ovf", 64'(s_ovf), 64'(1));
    chk("sat_level", 64'(s_level), 64'(4));
    s_clear = 1'b1;
    @(negedge clk);
    s_clear = 1'b0;
    chk("sat_clear_lost", 64'(s_lost), 64'(0));
    chk("sat_clear_ovf", 64'(s_ovf), 64'(0));
    s_clear = 1'b1;
    sbus.rec_ready = 1'b1;
    sbus.rec_data  = 47'h3;
    @(negedge clk);
    s_clear = 1'b0;
    sbus.rec_ready = 1'b0;
    chk("clear_drop_lost", 64'(s_lost), 64'(1));
    chk("clear_drop_ovf", 64'(s_ovf), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
